// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, HI/LO registers and an iterative
// 32-cycle multiply/divide unit that stalls the front of the pipe.
// Build option: define EXE_DIV_EN to enable DIV/DIVU (opcodes 0E/0F);
// without it those opcodes behave as unknown operations.
module exe_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  EXE_alu_ctrl,
    input  logic [31:0] EXE_a,
    input  logic [31:0] EXE_b,
    input  logic [31:0] EXE_ex_imm,
    input  logic        EXE_s_b,
    output logic [31:0] EXE_result,
    output logic        EXE_zero,
    output logic        EXE_stall
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_NOR   = 6'h05;
    localparam logic [5:0] OP_SLT   = 6'h06;
    localparam logic [5:0] OP_SLTU  = 6'h07;
    localparam logic [5:0] OP_SLL   = 6'h08;
    localparam logic [5:0] OP_SRL   = 6'h09;
    localparam logic [5:0] OP_SRA   = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0B;
    localparam logic [5:0] OP_MULT  = 6'h0C;
    localparam logic [5:0] OP_MULTU = 6'h0D;
`ifdef EXE_DIV_EN
    localparam logic [5:0] OP_DIV   = 6'h0E;
    localparam logic [5:0] OP_DIVU  = 6'h0F;
`endif
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MFLO  = 6'h11;
    localparam logic [5:0] OP_MTHI  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     acc_q, acc_d;       // {partial product | remainder, multiplier | quotient}
    logic [31:0]     den_q, den_d;       // multiplicand or divisor magnitude
    logic [31:0]     dvd_q, dvd_d;       // raw dividend, returned on divide-by-zero
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;       // product / quotient sign
    logic            neg_rem_q, neg_rem_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;

    logic [31:0]     opb;
    logic            is_mul, is_div, is_sgn;
    logic [31:0]     mag_a, mag_b;
    logic [32:0]     step_sum, step_diff;
    logic [63:0]     acc_step, prod;
    logic [31:0]     quo, rem;

    // Operand B select and multiply/divide decode
    always_comb begin
        opb    = EXE_s_b ? EXE_ex_imm : EXE_b;
        is_mul = (EXE_alu_ctrl == OP_MULT) || (EXE_alu_ctrl == OP_MULTU);
`ifdef EXE_DIV_EN
        is_div = (EXE_alu_ctrl == OP_DIV) || (EXE_alu_ctrl == OP_DIVU);
        is_sgn = (EXE_alu_ctrl == OP_MULT) || (EXE_alu_ctrl == OP_DIV);
`else
        is_div = 1'b0;
        is_sgn = (EXE_alu_ctrl == OP_MULT);
`endif
        mag_a  = (is_sgn && EXE_a[31]) ? (~EXE_a + 32'd1) : EXE_a;
        mag_b  = (is_sgn && opb[31])   ? (~opb + 32'd1)   : opb;
    end

    // One shift-add or restoring-divide iteration, plus final sign fix-up
    always_comb begin
        step_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, den_q} : 33'd0);
        step_diff = acc_q[63:31] - {1'b0, den_q};
        if (is_div_q) begin
            acc_step = step_diff[32] ? {acc_q[62:0], 1'b0}
                                     : {step_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_step = {step_sum, acc_q[31:1]};
        end
        prod = neg_q     ? (~acc_step + 64'd1)          : acc_step;
        quo  = neg_q     ? (~acc_step[31:0] + 32'd1)    : acc_step[31:0];
        rem  = neg_rem_q ? (~acc_step[63:32] + 32'd1)   : acc_step[63:32];
    end

    // Multiply/divide sequencer and HI/LO next-state
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        den_d     = den_q;
        dvd_d     = dvd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        EXE_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mul || is_div) begin
                    EXE_stall = 1'b1;
                    state_d   = S_BUSY;
                    count_d   = '0;
                    is_div_d  = is_div;
                    neg_d     = is_sgn && (EXE_a[31] ^ opb[31]);
                    neg_rem_d = is_sgn && EXE_a[31];
                    dvd_d     = EXE_a;
                    if (is_div) begin
                        acc_d = {32'd0, mag_a};
                        den_d = mag_b;
                    end else begin
                        acc_d = {32'd0, mag_b};
                        den_d = mag_a;
                    end
                end else if (EXE_alu_ctrl == OP_MTHI) begin
                    hi_d = EXE_a;
                end else if (EXE_alu_ctrl == OP_MTLO) begin
                    lo_d = EXE_a;
                end
            end
            S_BUSY: begin
                EXE_stall = 1'b1;
                acc_d     = acc_step;
                count_d   = count_q + CW'(1);
                if (count_q == CW'(XLEN - 1)) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (den_q == 32'd0) begin
                        hi_d = dvd_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer, datapath and HI/LO registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            den_q     <= '0;
            dvd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            den_q     <= den_d;
            dvd_q     <= dvd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Single-cycle ALU result; multiply/divide and unknown codes read as 0
    always_comb begin
        EXE_result = '0;
        case (EXE_alu_ctrl)
            OP_ADD:  EXE_result = EXE_a + opb;
            OP_SUB:  EXE_result = EXE_a - opb;
            OP_AND:  EXE_result = EXE_a & opb;
            OP_OR:   EXE_result = EXE_a | opb;
            OP_XOR:  EXE_result = EXE_a ^ opb;
            OP_NOR:  EXE_result = ~(EXE_a | opb);
            OP_SLT:  EXE_result = {31'd0, $signed(EXE_a) < $signed(opb)};
            OP_SLTU: EXE_result = {31'd0, EXE_a < opb};
            OP_SLL:  EXE_result = opb << EXE_a[4:0];
            OP_SRL:  EXE_result = opb >> EXE_a[4:0];
            OP_SRA:  EXE_result = 32'($signed(opb) >>> EXE_a[4:0]);
            OP_LUI:  EXE_result = {opb[15:0], 16'h0000};
            OP_MFHI: EXE_result = hi_q;
            OP_MFLO: EXE_result = lo_q;
            default: EXE_result = '0;
        endcase
        EXE_zero = (EXE_result == 32'd0);
    end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the stage.
module tb_exe_stage;

`ifdef EXE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'h00;
    logic [31:0] a = '0, b = '0, imm = '0;
    logic        sb = 1'b0;
    logic [31:0] result;
    logic        zero, stall;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    int          cyc = 0;       // 0 idle, 1..32 iterating, 33 result-ready cycle
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [5:0]  cap_op = '0;
    logic [31:0] cap_a = '0, cap_b = '0;

    exe_stage dut (
        .clock        (clock),
        .reset        (reset),
        .EXE_alu_ctrl (op),
        .EXE_a        (a),
        .EXE_b        (b),
        .EXE_ex_imm   (imm),
        .EXE_s_b      (sb),
        .EXE_result   (result),
        .EXE_zero     (zero),
        .EXE_stall    (stall)
    );

    always #5 clock = ~clock;

    function automatic bit is_md(input logic [5:0] o);
        return (o == 6'h0C) || (o == 6'h0D) || (DIV_EN && ((o == 6'h0E) || (o == 6'h0F)));
    endfunction

    function automatic logic [31:0] f_alu(input logic [5:0] o, input logic [31:0] x, y, hi, lo);
        logic [4:0] sh;
        sh = x[4:0];
        case (o)
            6'h00: return x + y;
            6'h01: return x - y;
            6'h02: return x & y;
            6'h03: return x | y;
            6'h04: return x ^ y;
            6'h05: return ~(x | y);
            6'h06: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            6'h07: return (x < y) ? 32'd1 : 32'd0;
            6'h08: return y << sh;
            6'h09: return y >> sh;
            6'h0A: return 32'($signed(y) >>> sh);
            6'h0B: return {y[15:0], 16'h0000};
            6'h10: return hi;
            6'h11: return lo;
            default: return 32'd0;
        endcase
    endfunction

    // {HI, LO} produced by a multiply/divide
    function automatic logic [63:0] md_result(input logic [5:0] o, input logic [31:0] x, y);
        logic signed [63:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            6'h0C: return 64'(sx * sy);
            6'h0D: return {32'd0, x} * {32'd0, y};
            6'h0E: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            6'h0F: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // model state update
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hi <= '0;
            m_lo <= '0;
            cyc  <= 0;
        end else if (cyc == 0) begin
            if (is_md(op)) begin
                cyc    <= 1;
                cap_op <= op;
                cap_a  <= a;
                cap_b  <= sb ? imm : b;
            end else if (op == 6'h12) begin
                m_hi <= a;
            end else if (op == 6'h13) begin
                m_lo <= a;
            end
        end else if (cyc == 32) begin
            {m_hi, m_lo} <= md_result(cap_op, cap_a, cap_b);
            cyc <= 33;
        end else if (cyc == 33) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clock) begin
        logic [31:0] er;
        logic        es;
        if (cmp_en && reset === 1'b1) begin
            es = ((cyc >= 1) && (cyc <= 32)) || ((cyc == 0) && is_md(op));
            er = is_md(op) ? 32'd0 : f_alu(op, a, sb ? imm : b, m_hi, m_lo);
            check("model result", result, er);
            check("model zero", {31'd0, zero}, {31'd0, er == 32'd0});
            check("model stall", {31'd0, stall}, {31'd0, es});
        end
    end

    task automatic drive(input logic [5:0] o, input logic [31:0] ia, ib, iimm, input logic isb);
        @(posedge clock);
        #1;
        op = o; a = ia; b = ib; imm = iimm; sb = isb;
    endtask

    task automatic alu_chk(input string name, input logic [5:0] o, input logic [31:0] ia, ib, iimm,
                           input logic isb, input logic [31:0] exp);
        drive(o, ia, ib, iimm, isb);
        @(negedge clock);
        check(name, result, exp);
    endtask

    // issue a multiply/divide, scramble operands mid-operation, count stall cycles
    task automatic md(input string name, input logic [5:0] o, input logic [31:0] ia, ib, input int exp_stall);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        drive(o, ia, ib, 32'd0, 1'b0);
        while (!done) begin
            @(negedge clock);
            if (stall) begin
                n++;
                if (n == 5) begin
                    #1;
                    a = ~ia;
                    b = ib ^ 32'h5A5A_5A5A;
                end
                if (n >= 40) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: stall still high after %0d cycles, required %0d", name, n, exp_stall);
                    done = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
        end
        check({name, " stall cycles"}, 32'(n), 32'(exp_stall));
    endtask

    initial begin
        #12;
        @(negedge clock);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset result", result, 32'd0);
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        alu_chk("add wrap", 6'h00, 32'hFFFF_FFFF, 32'd5, 32'd1, 1'b1, 32'd0);
        check("add wrap zero", {31'd0, zero}, 32'd1);
        alu_chk("sub", 6'h01, 32'd5, 32'd7, 32'd0, 1'b0, 32'hFFFF_FFFE);
        alu_chk("and", 6'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'h00F0_00F0);
        alu_chk("or",  6'h03, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'hFFF0_FFF0);
        alu_chk("xor", 6'h04, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'hFF00_FF00);
        alu_chk("nor", 6'h05, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        alu_chk("sra", 6'h0A, 32'd4, 32'h8000_0000, 32'd0, 1'b0, 32'hF800_0000);
        alu_chk("slt", 6'h06, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1);
        alu_chk("sltu", 6'h07, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0);
        alu_chk("sll masked", 6'h08, 32'h24, 32'd3, 32'd0, 1'b0, 32'h30);
        alu_chk("srl", 6'h09, 32'd31, 32'h8000_0000, 32'd0, 1'b0, 32'd1);
        alu_chk("lui", 6'h0B, 32'd0, 32'd0, 32'h1234_ABCD, 1'b1, 32'hABCD_0000);
        alu_chk("unknown", 6'h3F, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0);
        alu_chk("mthi", 6'h12, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 32'd0);
        check("mthi stall", {31'd0, stall}, 32'd0);
        alu_chk("mtlo", 6'h13, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0, 32'd0);
        alu_chk("mfhi after mthi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'h1234_5678);
        alu_chk("mflo after mtlo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'h9ABC_DEF0);

        md("mult", 6'h0C, 32'hFFFF_FFFD, 32'd5, 33);
        alu_chk("mult hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        alu_chk("mult lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFF1);
        md("multu", 6'h0D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        alu_chk("multu hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFE);
        alu_chk("multu lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0001);
        md("mult minint", 6'h0C, 32'h8000_0000, 32'h8000_0000, 33);
        alu_chk("mult minint hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'h4000_0000);
        alu_chk("mult minint lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

`ifdef EXE_DIV_EN
        md("div", 6'h0E, 32'hFFFF_FFF9, 32'd2, 33);
        alu_chk("div lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFD);
        alu_chk("div hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        md("divu by zero", 6'h0F, 32'd9, 32'd0, 33);
        alu_chk("divu0 lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        alu_chk("divu0 hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd9);
        md("div overflow", 6'h0E, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        alu_chk("divovf lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8000_0000);
        alu_chk("divovf hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        md("div neg divisor", 6'h0E, 32'd7, 32'hFFFF_FFFE, 33);
        alu_chk("divneg lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFD);
        alu_chk("divneg hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd1);
`else
        md("div disabled", 6'h0E, 32'd8, 32'd2, 0);
        check("div disabled result", result, 32'd0);
        md("divu disabled", 6'h0F, 32'd8, 32'd2, 0);
        alu_chk("div disabled hi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'h4000_0000);
        alu_chk("div disabled lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
`endif

        // abort a multiply with reset part-way through the iterations
        md("mult pre-abort", 6'h0C, 32'hFFFF_FFFD, 32'd5, 33);
        drive(6'h0C, 32'd3, 32'd7, 32'd0, 1'b0);
        repeat (12) @(negedge clock);
        check("abort busy stall", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b0;
        op = 6'h10;
        #1;
        check("abort stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        check("abort mfhi in reset", result, 32'd0);
        check("abort stall held", {31'd0, stall}, 32'd0);
        #3 reset = 1'b1;
        alu_chk("abort mfhi", 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        alu_chk("abort mflo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        md("mult after abort", 6'h0C, 32'd2, 32'd3, 33);
        alu_chk("mult after abort lo", 6'h11, 32'd0, 32'd0, 32'd0, 1'b0, 32'd6);

        drive(6'h00, 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
